// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer with a 1-cycle registered memory read and a 2-entry decode buffer.
// Optional feature macro FETCH_MISALIGN_TRAP_EN: a misaligned redirect traps into HALT instead of being rounded down.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        if_ready,
  output logic        misalign_err
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} fsm_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  fsm_t        state, state_next;
  logic        run;
  logic [31:0] pc;
  logic [31:0] inflight_pc;
  logic        inflight;
  entry_t      fifo_q [2];
  logic        rd_ptr, wr_ptr;
  logic [1:0]  count;
  logic [2:0]  credit;
  logic [31:0] target;
  logic        pop, push, issue, redir, trap;

  assign imem_addr = pc;
  assign if_valid  = (count != 2'd0);
  assign if_pc     = if_valid ? fifo_q[rd_ptr].pc    : '0;
  assign if_instr  = if_valid ? fifo_q[rd_ptr].instr : '0;

  assign pop   = if_valid & if_ready;
  assign redir = redirect_valid & run;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign trap   = redir & (redirect_pc[1:0] != 2'b00);
  assign target = redirect_pc;
`else
  assign trap   = 1'b0;
  assign target = redirect_pc & 32'hFFFF_FFFC;
`endif

  // Slots that will be occupied after this edge if we issue now; the memory word lands one cycle later.
  assign credit = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign issue  = run & fetch_en & ~redirect_valid & (credit < 3'd2);
  assign push   = inflight & ~redir;

  // FSM: state register
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  // FSM: next state (HALT is left only through reset)
  // NOTE: combinational blocks assign a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    if (state == RUN && trap) state_next = HALT;
  end

  // FSM: outputs
  always_comb begin
    run = (state == RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      count       <= 2'd0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= pc;
        pc          <= pc + 32'd4;
      end
      if (redir) begin
        count  <= 2'd0;
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
        if (!trap) pc <= target;
      end else begin
        if (push) wr_ptr <= ~wr_ptr;
        if (pop)  rd_ptr <= ~rd_ptr;
        count <= count + {1'b0, push} - {1'b0, pop};
      end
    end
  end

  // NOTE: buffer storage has no reset; outputs are gated by if_valid so stale slots are never visible.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr] <= '{pc: inflight_pc, instr: imem_rdata};
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (reset)     misalign_err <= 1'b0;
    else if (trap) misalign_err <= 1'b1;
  end
`else
  assign misalign_err = 1'b0;
`endif

endmodule
